// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Instruction fetch front end. Issues sequential word fetches
//               to a memory with one cycle of read latency and buffers the
//               returned instructions in a 2-entry FIFO. Decode drains the
//               FIFO through a valid/ready handshake. A branch/jump redirect
//               flushes everything in flight and restarts at the target.
//
// Ports       :
//   clk            in   1   clock, all state updates on the rising edge
//   reset_n        in   1   asynchronous active-low reset
//   fetch_en       in   1   permits new fetch issues
//   imem_addr      out  32  word index {2'b00, fetch_pc[31:2]}
//   imem_req       out  1   current imem_addr is an accepted issue
//   imem_instr     in   32  read data, valid one clock after imem_addr
//   if_valid       out  1   instruction available to decode
//   if_ready       in   1   decode accepts the head instruction
//   if_instr       out  32  instruction at FIFO head
//   if_pc          out  32  byte PC of if_instr
//   redirect_valid in   1   redirect request
//   redirect_pc    in   32  redirect target (bits [1:0] ignored)
//
// Revision    : 1.0  initial release
// ============================================================================

module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        fetch_en,
    output logic [31:0] imem_addr,
    output logic        imem_req,
    input  logic [31:0] imem_instr,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
);

    // ------------------------------------------------------------------------
    // Constants and types
    // ------------------------------------------------------------------------
    localparam logic [2:0]  c_fifo_depth = 3'd2;
    localparam logic [31:0] c_pc_step    = 32'd4;

    typedef enum logic [0:0] {
        BOOT = 1'b0,
        RUN  = 1'b1
    } state_t;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_t      r_state;
    state_t      w_state_next;

    logic [31:0] r_fetch_pc;
    logic        r_inflight;
    logic [31:0] r_inflight_pc;

    logic [31:0] r_fifo_pc    [0:1];
    logic [31:0] r_fifo_instr [0:1];
    logic        r_rd_ptr;
    logic        r_wr_ptr;
    logic [1:0]  r_count;

    // ------------------------------------------------------------------------
    // Combinational control
    // ------------------------------------------------------------------------
    logic        w_issue;
    logic        w_push;
    logic        w_pop;
    logic [2:0]  w_occupancy;
    logic [31:0] w_redirect_pc_aligned;
    logic        w_unused;

    // Low address bits of the redirect target carry no information for a
    // word-aligned fetch stream.
    assign w_unused              = ^redirect_pc[1:0];
    assign w_redirect_pc_aligned = {redirect_pc[31:2], 2'b00};

    // A redirect hides the head entry so decode never sees a stale
    // instruction in the cycle the flush happens.
    assign if_valid = (r_count != 2'd0) && !redirect_valid;
    assign w_pop    = if_valid && if_ready;

    // Data coming back from the memory is only kept when no redirect is
    // killing it. r_inflight is never set outside RUN.
    assign w_push   = r_inflight && !redirect_valid;

    // Occupancy the FIFO will have once this cycle's pop and next cycle's
    // push of the in-flight word are accounted for. Issuing only while this
    // is below the depth guarantees the next push always finds room.
    // A pop implies r_count >= 1, so the subtraction never underflows.
    assign w_occupancy = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= BOOT;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next state and issue decision
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_issue      = 1'b0;
        case (r_state)
            BOOT: begin
                // One idle cycle after reset release, no issue.
                w_state_next = RUN;
            end
            RUN: begin
                w_issue = fetch_en && !redirect_valid && (w_occupancy < c_fifo_depth);
            end
            default: begin
                w_state_next = BOOT;
            end
        endcase
    end

    assign imem_req  = w_issue;
    assign imem_addr = {2'b00, r_fetch_pc[31:2]};

    // ------------------------------------------------------------------------
    // Fetch PC and in-flight tracking
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_fetch_pc    <= RESET_PC;
            r_inflight    <= 1'b0;
            r_inflight_pc <= RESET_PC;
        end else if (redirect_valid) begin
            // In BOOT nothing is in flight, so this only moves fetch_pc.
            r_fetch_pc <= w_redirect_pc_aligned;
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                // Plain 32-bit add: FFFF_FFFC wraps to 0.
                r_fetch_pc    <= r_fetch_pc + c_pc_step;
                r_inflight_pc <= r_fetch_pc;
            end
        end
    end

    // ------------------------------------------------------------------------
    // FIFO pointers and count
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else if (redirect_valid) begin
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

    // ------------------------------------------------------------------------
    // FIFO storage. Payload needs no reset: r_count gates its visibility.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_pc[r_wr_ptr]    <= r_inflight_pc;
            r_fifo_instr[r_wr_ptr] <= imem_instr;
        end
    end

    assign if_pc    = r_fifo_pc[r_rd_ptr];
    assign if_instr = r_fifo_instr[r_rd_ptr];

    // ------------------------------------------------------------------------
    // The issue rule must never let the memory return into a full FIFO.
    // ------------------------------------------------------------------------
`ifndef SYNTHESIS
    a_no_push_when_full : assert property (
        @(posedge clk) disable iff (!reset_n)
        !(w_push && (r_count == 2'd2))
    ) else $error("fetch_unit: push into full FIFO");
`endif

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit
// Description : Self-checking bench for fetch_unit. A table drives the boot
//               sequence; hand-written sequences cover stall, redirect,
//               fetch_en gating, mid-stream reset and redirect during BOOT.
//               A queue scoreboard checks every instruction handed to decode.
//               A second instance with RESET_PC = FFFF_FFF8 covers PC wrap.
// Revision    : 1.0  initial release
// ============================================================================

module tb_fetch_unit;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic        fetch_en;
    logic        if_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        imem_req;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;

    logic [31:0] wr_imem_addr;
    logic [31:0] wr_imem_instr;
    logic        wr_imem_req;
    logic        wr_if_valid;
    logic [31:0] wr_if_instr;
    logic [31:0] wr_if_pc;

    fetch_unit dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .fetch_en       (fetch_en),
        .imem_addr      (imem_addr),
        .imem_req       (imem_req),
        .imem_instr     (imem_instr),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
        .clk            (clk),
        .reset_n        (reset_n),
        .fetch_en       (1'b1),
        .imem_addr      (wr_imem_addr),
        .imem_req       (wr_imem_req),
        .imem_instr     (wr_imem_instr),
        .if_valid       (wr_if_valid),
        .if_ready       (1'b1),
        .if_instr       (wr_if_instr),
        .if_pc          (wr_if_pc),
        .redirect_valid (1'b0),
        .redirect_pc    (32'h0)
    );

    // Memory model: word i reads as A000_0000 + i, one clock of latency.
    always @(posedge clk) begin
        imem_instr    <= 32'hA000_0000 + imem_addr;
        wr_imem_instr <= 32'hA000_0000 + wr_imem_addr;
    end

    function automatic logic [31:0] mem_word(input logic [31:0] pc);
        return 32'hA000_0000 + {2'b00, pc[31:2]};
    endfunction

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------------
    logic [31:0] exp_q [$];
    logic [31:0] sb_next = 32'h0;
    bit          sb_on   = 1'b0;

    task automatic push_seq(input int n);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(sb_next);
            sb_next = sb_next + 32'd4;
        end
    endtask

    task automatic monitor();
        logic [31:0] e;
        if (sb_on && if_valid && if_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL sb_unexpected: got pc %h, required no transfer", if_pc);
            end else begin
                e = exp_q.pop_front();
                chk("sb_pc", if_pc, e);
                chk("sb_instr", if_instr, mem_word(e));
            end
        end
    endtask

    // Drive inputs on the falling edge, sample 1 ns later.
    task automatic drive(input logic rst, input logic fe, input logic rdy,
                         input logic rv, input logic [31:0] rpc);
        @(negedge clk);
        reset_n        = rst;
        fetch_en       = fe;
        if_ready       = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
        #1;
        monitor();
    endtask

    task automatic drain(input int bound, input bit gapchk);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < bound) begin
            drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
            if (gapchk) chk("no_gap_valid", {31'd0, if_valid}, 32'd1);
            k++;
        end
        if (exp_q.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain_timeout: %0d entries left, required 0", exp_q.size());
        end
    endtask

    // ------------------------------------------------------------------------
    // Boot table
    // ------------------------------------------------------------------------
    typedef struct {
        logic        fe;
        logic        rdy;
        logic        exp_valid;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic [31:0] exp_pc;
        logic [31:0] exp_wpc;
    } vec_t;

    vec_t vt [7];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running, required finish");
        $fatal(1);
    end

    initial begin
        vt[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0,  32'h0};
        vt[1] = '{1'b1, 1'b1, 1'b0, 1'b1, 32'd0, 32'd0,  32'h0};
        vt[2] = '{1'b1, 1'b1, 1'b0, 1'b1, 32'd1, 32'd0,  32'h0};
        vt[3] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'd2, 32'd0,  32'hFFFF_FFF8};
        vt[4] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'd3, 32'd4,  32'hFFFF_FFFC};
        vt[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'd4, 32'd8,  32'h0000_0000};
        vt[6] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'd5, 32'd12, 32'h0000_0004};

        reset_n        = 1'b0;
        fetch_en       = 1'b1;
        if_ready       = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;

        // Reset state
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
            chk("rst_valid", {31'd0, if_valid}, 32'd0);
            chk("rst_req", {31'd0, imem_req}, 32'd0);
            chk("rst_addr", imem_addr, 32'h0);
            chk("rst_wrap_addr", wr_imem_addr, 32'h3FFF_FFFE);
        end

        // Boot: release in row 0, BOOT cycle, issue, push, then 1/cycle
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, vt[i].fe, vt[i].rdy, 1'b0, 32'h0);
            chk($sformatf("tbl%0d_valid", i), {31'd0, if_valid}, {31'd0, vt[i].exp_valid});
            chk($sformatf("tbl%0d_req", i), {31'd0, imem_req}, {31'd0, vt[i].exp_req});
            chk($sformatf("tbl%0d_addr", i), imem_addr, vt[i].exp_addr);
            chk($sformatf("tbl%0d_wrap_valid", i), {31'd0, wr_if_valid}, {31'd0, vt[i].exp_valid});
            if (vt[i].exp_valid) begin
                chk($sformatf("tbl%0d_pc", i), if_pc, vt[i].exp_pc);
                chk($sformatf("tbl%0d_instr", i), if_instr, mem_word(vt[i].exp_pc));
                chk($sformatf("tbl%0d_wrap_pc", i), wr_if_pc, vt[i].exp_wpc);
                chk($sformatf("tbl%0d_wrap_instr", i), wr_if_instr, mem_word(vt[i].exp_wpc));
            end
        end

        // Decode stall: FIFO fills, issue stops, fetch_pc holds at 24
        sb_next = 32'd16;
        sb_on   = 1'b1;
        push_seq(10);
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
            chk("stall_valid", {31'd0, if_valid}, 32'd1);
            chk("stall_head_pc", if_pc, 32'd16);
            chk("stall_req", {31'd0, imem_req}, 32'd0);
            chk("stall_addr", imem_addr, 32'd6);
        end
        drain(40, 1'b1);

        // Redirect to 0x43 while streaming
        sb_next = 32'h40;
        push_seq(6);
        drive(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0043);
        chk("redir_n_valid", {31'd0, if_valid}, 32'd0);
        chk("redir_n_req", {31'd0, imem_req}, 32'd0);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        chk("redir_n1_valid", {31'd0, if_valid}, 32'd0);
        chk("redir_n1_req", {31'd0, imem_req}, 32'd1);
        chk("redir_n1_addr", imem_addr, 32'h10);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        chk("redir_n2_valid", {31'd0, if_valid}, 32'd0);
        chk("redir_n2_addr", imem_addr, 32'h11);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        chk("redir_n3_valid", {31'd0, if_valid}, 32'd1);
        drain(20, 1'b1);

        // fetch_en low for 4 cycles: in-flight word still delivered
        push_seq(2);
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
            chk("fe_low_req", {31'd0, imem_req}, 32'd0);
            chk("fe_low_addr", imem_addr, {2'b00, sb_next[31:2]});
            if (i >= 2) chk("fe_low_valid", {31'd0, if_valid}, 32'd0);
        end
        chk("fe_low_delivered", 32'(exp_q.size()), 32'd0);
        push_seq(6);
        drain(20, 1'b0);

        // One-cycle reset mid-stream
        drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        chk("mrst_valid", {31'd0, if_valid}, 32'd0);
        chk("mrst_req", {31'd0, imem_req}, 32'd0);
        chk("mrst_addr", imem_addr, 32'h0);
        sb_next = 32'h0;
        push_seq(5);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        chk("mrst_boot_req", {31'd0, imem_req}, 32'd0);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        chk("mrst_c1_req", {31'd0, imem_req}, 32'd1);
        chk("mrst_c1_addr", imem_addr, 32'h0);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        chk("mrst_c2_valid", {31'd0, if_valid}, 32'd0);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        chk("mrst_c3_valid", {31'd0, if_valid}, 32'd1);
        drain(20, 1'b1);

        // Redirect during BOOT only moves fetch_pc
        drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        sb_next = 32'h100;
        push_seq(4);
        drive(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0101);
        chk("bootredir_valid", {31'd0, if_valid}, 32'd0);
        chk("bootredir_req", {31'd0, imem_req}, 32'd0);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        chk("bootredir_c1_req", {31'd0, imem_req}, 32'd1);
        chk("bootredir_c1_addr", imem_addr, 32'h40);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        chk("bootredir_c2_valid", {31'd0, if_valid}, 32'd0);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        chk("bootredir_c3_valid", {31'd0, if_valid}, 32'd1);
        drain(20, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
